// File: rtl/enc_onehot2bin.sv
`default_nettype none
// ============================================================================
// Module      : enc_onehot2bin
// Description : Two-stage pipelined one-hot to binary encoder with a
//               valid/ready handshake, backpressure, a per-word malformed
//               flag and a saturating, clearable error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_onehot2bin #(
   parameter int OH_W   = 15,
   parameter int BIN_W  = 4,
   parameter int ERRC_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OH_W-1:0]   in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BIN_W-1:0]  out,
   output logic              out_err,
   output logic [ERRC_W-1:0] err_cnt,
   input  logic              err_clr
);

   localparam int               C_PC_W     = $clog2(OH_W + 1);
   localparam logic [BIN_W-1:0] C_ERR_CODE = '1;
   localparam logic [ERRC_W-1:0] C_CNT_MAX  = '1;

   // stage 1 (capture) registers
   logic              r_s1_valid;
   logic [BIN_W-1:0]  r_s1_code;
   logic              r_s1_err;
   // stage 2 (output) registers
   logic              r_s2_valid;
   logic [BIN_W-1:0]  r_s2_code;
   logic              r_s2_err;
   logic [ERRC_W-1:0] r_err_cnt;

   logic [C_PC_W-1:0] w_popcnt;
   logic [BIN_W-1:0]  w_idx;
   logic              w_err;
   logic [BIN_W-1:0]  w_code;
   logic              w_s2_free;
   logic              w_s1_move;
   logic              w_accept;
   logic              w_acc_err;

   // Count set bits and remember the index of the highest one; the index is
   // only meaningful when exactly one bit is set.
   always_comb begin
      w_popcnt = '0;
      w_idx    = '0;
      for (int k = 0; k < OH_W; k++) begin
         if (in[k]) begin
            w_popcnt = w_popcnt + C_PC_W'(1);
            w_idx    = BIN_W'(k);
         end
      end
   end

   assign w_err  = (w_popcnt != C_PC_W'(1));
   assign w_code = w_err ? C_ERR_CODE : w_idx;

   // Handshake: stage 2 can take a word when empty or draining this cycle;
   // stage 1 can take a word when empty or moving forward this cycle. The
   // out_ready -> in_ready combinational path is intentional (no bubble).
   assign w_s2_free = !r_s2_valid || out_ready;
   assign w_s1_move = r_s1_valid && w_s2_free;
   assign in_ready  = !rst && (!r_s1_valid || w_s2_free);
   assign w_accept  = in_valid && in_ready;
   assign w_acc_err = w_accept && w_err;

   // Stage 1: load on acceptance, otherwise empty out when the word moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_code  <= '0;
         r_s1_err   <= 1'b0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_code  <= w_code;
         r_s1_err   <= w_err;
      end else if (w_s1_move) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage 2: take whatever stage 1 holds whenever it is free; hold on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_code  <= '0;
         r_s2_err   <= 1'b0;
      end else if (w_s2_free) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_code <= r_s1_code;
            r_s2_err  <= r_s1_err;
         end
      end
   end

   // Error counter: a clear and a same-cycle error give 1 (clear, then count);
   // otherwise count malformed acceptances up to saturation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (err_clr) begin
         r_err_cnt <= w_acc_err ? ERRC_W'(1) : '0;
      end else if (w_acc_err && (r_err_cnt != C_CNT_MAX)) begin
         r_err_cnt <= r_err_cnt + ERRC_W'(1);
      end
   end

   assign out_valid = r_s2_valid;
   assign out       = r_s2_code;
   assign out_err   = r_s2_err;
   assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_enc_onehot2bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_onehot2bin
// Description : Self-checking bench for enc_onehot2bin. Expected words are
//               queued at acceptance and popped when the output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_onehot2bin;

   localparam int OH_W   = 15;
   localparam int BIN_W  = 4;
   localparam int ERRC_W = 8;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [OH_W-1:0]   in;
   logic              out_valid;
   logic              out_ready;
   logic [BIN_W-1:0]  out;
   logic              out_err;
   logic [ERRC_W-1:0] err_cnt;
   logic              err_clr;

   int n_checks = 0;
   int n_pass   = 0;

   logic [4:0]        sb[$];      // {err, code}
   logic [ERRC_W-1:0] m_cnt = '0;
   logic              prev_stall = 1'b0;
   logic [4:0]        prev_word  = '0;

   enc_onehot2bin #(.OH_W(OH_W), .BIN_W(BIN_W), .ERRC_W(ERRC_W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_err   (out_err),
      .err_cnt   (err_cnt),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference encoder: {err, code}
   function automatic logic [4:0] ref_enc(input logic [OH_W-1:0] v);
      int idx = 0;
      if ($countones(v) != 1) return {1'b1, 4'hF};
      for (int k = 0; k < OH_W; k++) if (v[k]) idx = k;
      return {1'b0, 4'(idx)};
   endfunction

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic acc_err;
      logic [4:0] exp_w;
      check("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (prev_stall) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_word", 32'({out_err, out}), 32'(prev_word));
      end
      acc_err = 1'b0;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_empty_pop", 32'(sb.size()), 32'd1);
            else begin
               exp_w = sb.pop_front();
               check("out_word", 32'({out_err, out}), 32'(exp_w));
            end
         end
         if (in_valid && in_ready) begin
            exp_w = ref_enc(in);
            sb.push_back(exp_w);
            acc_err = exp_w[4];
         end
      end
      if (rst) begin
         m_cnt = '0;
         sb.delete();
      end else if (err_clr) m_cnt = acc_err ? 8'd1 : 8'd0;
      else if (acc_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      prev_stall = out_valid && !out_ready && !rst;
      prev_word  = {out_err, out};
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present a word and hold it until accepted (bounded)
   task automatic send(input logic [OH_W-1:0] w);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in       = w;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in = '0; out_ready = 1'b1; err_clr = 1'b0;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      tick();
      rst = 1'b0;

      // One-hot stream with latency check on the first word
      send(15'h0001);
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_cycle1", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      check("lat_cycle2_valid", 32'(out_valid), 32'd1);
      check("lat_cycle2_out", 32'(out), 32'd0);
      tick();
      for (int i = 1; i < OH_W; i++) send(OH_W'(1) << i);
      drain();
      check("stream_errcnt", 32'(err_cnt), 32'd0);

      // Malformed words
      send(15'h0000); send(15'h0003); send(15'h4001);
      drain();
      check("malformed_errcnt", 32'(err_cnt), 32'd3);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      @(negedge clk);
      check("clr_errcnt", 32'(err_cnt), 32'd0);
      tick();

      // Backpressure: two words buffer, third waits
      out_ready = 1'b0;
      in_valid  = 1'b1; in = 15'h0008;
      @(negedge clk); check("bp_rdy_w0", 32'(in_ready), 32'd1);
      tick(); in = 15'h0010;
      @(negedge clk); check("bp_rdy_w1", 32'(in_ready), 32'd1);
      tick(); in = 15'h0020;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_full_rdy", 32'(in_ready), 32'd0);
         check("bp_hold_out", 32'(out), 32'd3);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk); check("bp_release_rdy", 32'(in_ready), 32'd1);
      tick();
      drain();

      // Same-cycle clear and error
      for (int i = 0; i < 5; i++) send(15'h0000);
      drain();
      check("pre_clr_errcnt", 32'(err_cnt), 32'd5);
      err_clr = 1'b1;
      send(15'h0000);
      err_clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("clr_and_err", 32'(err_cnt), 32'd1);
      tick();

      // Saturation
      for (int i = 0; i < 300; i++) send(i[0] ? 15'h0003 : 15'h0000);
      drain();
      check("sat_errcnt", 32'(err_cnt), 32'd255);
      send(15'h0000); drain();
      check("sat_hold", 32'(err_cnt), 32'd255);

      // Mid-operation reset
      out_ready = 1'b0;
      send(15'h0002); send(15'h0004);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk); check("midrst_in_ready", 32'(in_ready), 32'd0);
      tick(); rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out", 32'(out), 32'd0);
      check("midrst_errcnt", 32'(err_cnt), 32'd0);
      tick();
      out_ready = 1'b1;
      send(15'h0100);
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_out", 32'(out), 32'd8);
      tick();
      drain();

      // Random soak
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) != 0) in = OH_W'(1) << $urandom_range(0, OH_W - 1);
         else in = OH_W'($urandom);
         tick();
      end
      drain();
      check("soak_errcnt", 32'(err_cnt), 32'(m_cnt));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/enc_onehot2bin.md
Name: enc_onehot2bin

Overview:
- Pipelined one-hot to binary encoder. It is the inverse of the team's binary-to-one-hot encoder: a 15-bit one-hot vector (bit k set means code k, k = 0..14) is converted back to a 4-bit code.
- It sits on the return path of the same interface and uses a valid/ready handshake with backpressure.
- Malformed inputs (all-zero or multi-hot vectors) are flagged per transaction and counted in a saturating error counter.

Parameters:
- OH_W, 15, one-hot input width; codes 0..OH_W-1.
- BIN_W, 4, binary output width; must satisfy 2^BIN_W > OH_W.
- ERRC_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  an input word is presented.
- in_ready  output  1  block accepts the input this cycle.
- in  input  OH_W  one-hot vector.
- out_valid  output  1  output word is valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out  output  BIN_W  binary code; all-ones (15) on error.
- out_err  output  1  current output word came from a malformed input.
- err_cnt  output  ERRC_W  count of malformed words accepted; saturates.
- err_clr  input  1  synchronously clears err_cnt.

Behaviour:
- Reset: one clock is used, and reset is synchronous and active-high on rst. While rst is high, at each clock edge:
  - s1_valid, s2_valid, out_valid, out_err and err_cnt all go to 0.
  - out goes to 0.
  - in_ready is 0 while rst is asserted.
  - Words in flight when reset asserts mid-operation are discarded.
- Stage 1 (capture):
  - An input is accepted when in_valid && in_ready.
  - At acceptance the block registers the code, popcount==1 status, and the error flag (err = popcount(in) != 1).
  - code = index of the single set bit. On err, code = 2^BIN_W-1 (15).
  - Bits of in at index >= OH_W do not exist; no code 15 is ever valid.
- Stage 2 (output register): drives out, out_err and out_valid = s2_valid.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - s1 moves to s2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is a combinational path from out_ready to in_ready and is accepted.
  - On a cycle with acceptance and an s1 move together, s1 reloads with the new word. No bubble.
- Latency and throughput:
  - Accepted word appears on out_valid 2 cycles after acceptance if never stalled.
  - Sustained throughput is 1 word/cycle.
- Stall: while out_valid && !out_ready, out, out_err and out_valid hold stable. Up to 2 words are buffered (s2 + s1); then in_ready = 0.
- Pipeline ordering is strict FIFO; no reordering or dropping.
- err_cnt:
  - Increments by 1 at stage-1 acceptance of a malformed word.
  - Saturates at 2^ERRC_W-1; further errors leave it unchanged.
- err_clr:
  - err_clr sets err_cnt to 0 at the edge.
  - If err_clr and an error acceptance occur in the same cycle, the result is err_cnt = 1 (clear, then count).
  - rst has priority over err_clr.
- in is ignored when in_valid = 0 or in_ready = 0; no state changes.
- Output register values when out_valid = 0 are don't-care, except at reset (0).

Test Plan:
- Reset then stream in = 15'h0001, 0002, 0004, … 4000 with out_ready = 1 every cycle:
  - out_valid first rises 2 cycles after the first accept.
  - out = 0,1,2,…,14 consecutively; out_err = 0; err_cnt = 0.
- Malformed inputs: in = 15'h0000, then 15'h0003, then 15'h4001:
  - Each gives out = 4'hF with out_err = 1; err_cnt = 3.
  - Then assert err_clr alone, giving err_cnt = 0.
- Backpressure: hold out_ready = 0 and send 3 words (in = 0x0008, 0x0010, 0x0020):
  - in_ready drops to 0 after 2 accepts; the third waits.
  - out holds 3 stable.
  - Release out_ready: out = 3, 4, 5 in order with no loss or duplication.
- Same-cycle clear and error: err_cnt = 5, then assert err_clr with an accepted in = 15'h0000 → err_cnt = 1 next cycle.
  - Saturation: with ERRC_W = 8, accept 300 malformed words → err_cnt = 255 and holds.
- Mid-operation reset: 2 words in flight, out_ready = 0, assert rst for 1 cycle:
  - out_valid = 0, out = 0, err_cnt = 0 after the edge; in_ready = 0 during rst.
  - The next accepted word 15'h0100 emerges as out = 8 after 2 cycles.
- Random soak: random in_valid, out_ready and in (75% one-hot) checked against a reference queue model. Output order, codes, out_err and the final err_cnt must all match.
